clmul16_karatsuba_seq: RTL and testbench

// - Sequencer for a 16x16 carry-less (GF(2)) multiply. Karatsuba split into three 8x8 partial products computed
//   one per cycle on a single shared 8x8 carry-less core. Partials are folded by the z0/z1/z2 overlap-XOR combine.
// - Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.

---
 rtl/clmul_pkg.sv | 35 +++
 rtl/clmul_core.sv | 23 ++
 rtl/clmul16_karatsuba_seq.sv | 133 +++++++++++++
 tb/tb_clmul16_karatsuba_seq.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clmul_pkg.sv
// Shared definitions for the 16x16 Karatsuba carry-less multiplier.
//   state_t        : sequencer states
//   W_DEF / H_DEF  : default operand width and half width
//   clmul_combine  : overlap-XOR fold of the three partial products
package clmul_pkg;

  localparam int W_DEF = 16;
  localparam int H_DEF = W_DEF / 2;

  typedef enum logic [2:0] {
    IDLE,
    MUL_LO,
    MUL_HI,
    MUL_MID,
    DONE
  } state_t;

  // y = z0 ^ (z1 << H) ^ (z2 << W), where z1 is the already-corrected middle
  // term (t ^ z0 ^ z2). Partials are zero-extended before shifting.
  function automatic logic [2*W_DEF-2:0] clmul_combine(
    input logic [2*H_DEF-2:0] z0,
    input logic [2*H_DEF-2:0] z1,
    input logic [2*H_DEF-2:0] z2
  );
    logic [2*W_DEF-2:0] e0, e1, e2;
    e0 = '0;
    e1 = '0;
    e2 = '0;
    e0[2*H_DEF-2:0] = z0;
    e1[2*H_DEF-2:0] = z1;
    e2[2*H_DEF-2:0] = z2;
    return e0 ^ (e1 << H_DEF) ^ (e2 << W_DEF);
  endfunction

endpackage

// File: rtl/clmul_core.sv
// Purely combinational HxH carry-less (GF(2)) multiplier.
//   a, b : H-bit operands, bit i = coefficient of x^i
//   p    : 2H-1 bit product, XOR of b-gated, left-shifted copies of a
module clmul_core #(
  parameter int H = 8
) (
  input  logic [H-1:0]   a,
  input  logic [H-1:0]   b,
  output logic [2*H-2:0] p
);

  localparam int PW = 2 * H - 1;

  always_comb begin
    p = '0;
    for (int unsigned i = 0; i < H; i++) begin
      if (b[i]) begin
        p = p ^ (PW'(a) << i);
      end
    end
  end

endmodule

// File: rtl/clmul16_karatsuba_seq.sv
// Sequenced 16x16 carry-less multiply using a Karatsuba split over one shared
// HxH core: z0 = lo*lo, z2 = hi*hi, t = (lo^hi)*(lo^hi), one per cycle.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (ready only in IDLE)
//   a, b                 : W-bit operands
//   out_valid / out_ready: result handshake (valid held until taken)
//   y                    : 2W-1 bit product, holds after handoff
//   busy                 : high in every state except IDLE
module clmul16_karatsuba_seq
  import clmul_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-2:0] y,
  output logic           busy
);

  localparam int H  = W / 2;
  localparam int PW = 2 * H - 1;
  localparam int YW = 2 * W - 1;

  state_t        state;
  logic [W-1:0]  a_r, b_r;
  logic [PW-1:0] z0_r, z2_r;
  logic [H-1:0]  core_a, core_b;
  logic [PW-1:0] core_p;
  logic [PW-1:0] z1;
  logic [YW-1:0] y_next;

  // Core inputs are forced to zero outside the multiply states.
  always_comb begin
    core_a = '0;
    core_b = '0;
    case (state)
      MUL_LO: begin
        core_a = a_r[H-1:0];
        core_b = b_r[H-1:0];
      end
      MUL_HI: begin
        core_a = a_r[W-1:H];
        core_b = b_r[W-1:H];
      end
      MUL_MID: begin
        core_a = a_r[H-1:0] ^ a_r[W-1:H];
        core_b = b_r[H-1:0] ^ b_r[W-1:H];
      end
      default: begin
        core_a = '0;
        core_b = '0;
      end
    endcase
  end

  clmul_core #(.H(H)) u_core (
    .a (core_a),
    .b (core_b),
    .p (core_p)
  );

  // Middle term is folded straight from the core output so y lands on the
  // same edge that leaves MUL_MID.
  assign z1 = core_p ^ z0_r ^ z2_r;

  generate
    if (W == W_DEF) begin : g_pkg_combine
      assign y_next = clmul_combine(z0_r, z1, z2_r);
    end else begin : g_gen_combine
      assign y_next = YW'(z0_r) ^ (YW'(z1) << H) ^ (YW'(z2_r) << W);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      z0_r      <= '0;
      z2_r      <= '0;
      y         <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= MUL_LO;
          end
        end
        MUL_LO: begin
          z0_r  <= core_p;
          state <= MUL_HI;
        end
        MUL_HI: begin
          z2_r  <= core_p;
          state <= MUL_MID;
        end
        MUL_MID: begin
          y         <= y_next;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clmul16_karatsuba_seq.sv
module tb_clmul16_karatsuba_seq;
  import clmul_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [30:0] y;
  logic        busy;

  clmul16_karatsuba_seq #(.W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          errs    = 0;
  int          cyc     = 0;
  int          out_cnt = 0;
  int          last_hs = 0;
  bit          b2b       = 1'b0;
  bit          have_last = 1'b0;
  logic [30:0] sb[$];

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [30:0] ref_clmul(input logic [15:0] x, input logic [15:0] z);
    logic [30:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        if (x[i] && z[j]) r[i+j] = ~r[i+j];
    return r;
  endfunction

  function automatic logic [14:0] ref8(input logic [7:0] x, input logic [7:0] z);
    logic [14:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        if (x[i] && z[j]) r[i+j] = ~r[i+j];
    return r;
  endfunction

  // Scoreboard consumer: a transfer happens at the posedge following a
  // negedge where out_valid and out_ready are both high.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      out_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_output", 32'(sb.size()), 32'd1);
      end else begin
        logic [30:0] e;
        e = sb.pop_front();
        check("y", 32'(y), 32'(e));
      end
      if (b2b && have_last) check("b2b_interval", 32'(cyc - last_hs), 32'd5);
      last_hs   = cyc;
      have_last = b2b;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
  endtask

  task automatic send(input logic [15:0] x, input logic [15:0] z, input logic [30:0] e);
    wait_ready();
    a        = x;
    b        = z;
    in_valid = 1'b1;
    sb.push_back(e);
    step();
    in_valid = 1'b0;
    a        = 'x;
    b        = 'x;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      step();
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] va[7];
    logic [15:0] vb[7];
    logic [30:0] vy[7];
    logic [30:0] yh;
    logic [14:0] z0, z2, t;
    logic [15:0] ra, rb;
    int          oc0, pushed, guard;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    repeat (3) step();
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_y",         32'(y),         32'd0);
    rst_n = 1'b1;
    step();

    // Directed identity, boundary and cross-half vectors
    va[0] = 16'h0001; vb[0] = 16'h0001; vy[0] = 31'h0000_0001;
    va[1] = 16'h8000; vb[1] = 16'h8000; vy[1] = 31'h4000_0000;
    va[2] = 16'h0100; vb[2] = 16'h0100; vy[2] = 31'h0001_0000;
    va[3] = 16'h00FF; vb[3] = 16'h0101; vy[3] = 31'h0000_FFFF;
    va[4] = 16'hFFFF; vb[4] = 16'h0001; vy[4] = 31'h0000_FFFF;
    va[5] = 16'h0001; vb[5] = 16'hFFFF; vy[5] = 31'h0000_FFFF;
    va[6] = 16'hFFFF; vb[6] = 16'hFFFF; vy[6] = 31'h5555_5555;
    for (int i = 0; i < 7; i++) begin
      send(va[i], vb[i], vy[i]);
      drain();
    end

    // Worst case again, expected value built from the Karatsuba fold
    z0 = ref8(8'hFF, 8'hFF);
    z2 = ref8(8'hFF, 8'hFF);
    t  = ref8(8'hFF ^ 8'hFF, 8'hFF ^ 8'hFF);
    send(16'hFFFF, 16'hFFFF, clmul_combine(z0, t ^ z0 ^ z2, z2));
    drain();

    // Latency and output back-pressure
    out_ready = 1'b0;
    wait_ready();
    a        = 16'h1234;
    b        = 16'h5678;
    in_valid = 1'b1;
    sb.push_back(ref_clmul(16'h1234, 16'h5678));
    step();
    in_valid = 1'b0;
    a        = 'x;
    b        = 'x;
    check("lat_e0_busy",     32'(busy),      32'd1);
    check("lat_e0_in_ready", 32'(in_ready),  32'd0);
    check("lat_e0_valid",    32'(out_valid), 32'd0);
    step();
    check("lat_e1_valid", 32'(out_valid), 32'd0);
    step();
    check("lat_e2_valid", 32'(out_valid), 32'd0);
    step();
    check("lat_e3_valid", 32'(out_valid), 32'd1);
    check("lat_e3_y", 32'(y), 32'(ref_clmul(16'h1234, 16'h5678)));
    yh = y;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        in_valid = 1'b1;
        a        = 16'hAAAA;
        b        = 16'h5555;
      end
      step();
      check("hold_y",        32'(y),         32'(yh));
      check("hold_in_ready", 32'(in_ready),  32'd0);
      check("hold_valid",    32'(out_valid), 32'd1);
    end
    in_valid  = 1'b0;
    a         = 'x;
    b         = 'x;
    out_ready = 1'b1;
    step();
    check("handoff_valid",    32'(out_valid), 32'd0);
    check("handoff_in_ready", 32'(in_ready),  32'd1);
    check("handoff_busy",     32'(busy),      32'd0);
    check("handoff_sb",       32'(sb.size()), 32'd0);
    check("y_held",           32'(y),         32'(yh));

    // Reset in the middle of an operation
    oc0 = out_cnt;
    wait_ready();
    a        = 16'hBEEF;
    b        = 16'hCAFE;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a        = 'x;
    b        = 'x;
    step();
    check("midop_busy", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("midop_rst_valid",    32'(out_valid), 32'd0);
    check("midop_rst_y",        32'(y),         32'd0);
    check("midop_rst_in_ready", 32'(in_ready),  32'd1);
    check("midop_rst_busy",     32'(busy),      32'd0);
    step();
    step();
    rst_n = 1'b1;
    repeat (8) step();
    check("midop_no_output", 32'(out_cnt - oc0), 32'd0);
    send(16'h0003, 16'h0003, 31'h0000_0005);
    drain();

    // Back-to-back: in_valid held high, out_ready tied high
    oc0 = out_cnt;
    b2b = 1'b1;
    wait_ready();
    ra = 16'($urandom);
    rb = 16'($urandom);
    a        = ra;
    b        = rb;
    in_valid = 1'b1;
    sb.push_back(ref_clmul(ra, rb));
    pushed = 1;
    guard  = 0;
    while (pushed < 200 && guard < 3000) begin
      step();
      guard++;
      if (in_ready === 1'b1) begin
        ra = 16'($urandom);
        rb = 16'($urandom);
        a  = ra;
        b  = rb;
        sb.push_back(ref_clmul(ra, rb));
        pushed++;
      end
    end
    check("b2b_pushed", 32'(pushed), 32'd200);
    step();
    in_valid = 1'b0;
    a        = 'x;
    b        = 'x;
    drain();
    step();
    b2b = 1'b0;
    check("b2b_count", 32'(out_cnt - oc0), 32'd200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
